// File: rtl/chanlink_arb_pkg.sv
// Shared definitions for the channel-link event arbiter: FSM encoding,
// ERR_STAT bit positions, default idle word and the word-count helper.
package chanlink_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int ERR_TMO   = 0;
  localparam int ERR_TRUNC = 1;
  localparam int ERR_STRAY = 2;

  localparam logic [15:0] IDLE_WRD_DEF = 16'h50BC;

  // Event word count sticks at all-ones instead of wrapping.
  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    if (v == 12'hFFF) begin
      return v;
    end else begin
      return v + 12'd1;
    end
  endfunction

endpackage

// File: rtl/chanlink_evt_arb_rr_prio_enc.sv
// Round-robin priority encoder: picks the first requester at or after PTR,
// wrapping from NREQ-1 back to 0.
module rr_prio_enc #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] REQ,
  input  logic [PW-1:0]   PTR,
  output logic [NREQ-1:0] SEL,
  output logic            VLD
);

  logic [PW-1:0] idx_s;
  logic          hit_s;

  // Linear scan from PTR; the first hit masks every later candidate.
  always_comb begin
    SEL   = {NREQ{1'b0}};
    VLD   = 1'b0;
    idx_s = {PW{1'b0}};
    hit_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s      = PW'((int'(PTR) + k) % NREQ);
      hit_s      = !VLD && REQ[idx_s];
      SEL[idx_s] = SEL[idx_s] | hit_s;
      VLD        = VLD | hit_s;
    end
  end

endmodule

// File: rtl/chanlink_evt_arb.sv
// Event-granular round-robin arbiter sharing one 16-bit TX path between NREQ
// readout FIFOs. Define CHANLINK_ARB_TMO_EN to enable the grant timeout.
module chanlink_evt_arb
  import chanlink_arb_pkg::*;
#(
  parameter int          NREQ     = 4,
  parameter int          IDLE_GAP = 2,
  parameter int          TMO_CYC  = 1023,
  parameter logic [15:0] IDLE_WRD = IDLE_WRD_DEF
) (
  input  logic                 RCLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      DVALID,
  input  logic [16*NREQ-1:0]   DOUT,
  input  logic [NREQ-1:0]      LAST_WRD,
  input  logic                 CLR_ERR,
  output logic [NREQ-1:0]      GNT,
  output logic [15:0]          TXD,
  output logic                 TX_VLD,
  output logic                 TX_SOF,
  output logic                 TX_EOF,
  output logic [15:0]          EVT_CNT,
  output logic [11:0]          WRD_CNT,
  output logic [2:0]           ERR_STAT
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]      state_r;
  logic [PW-1:0]   ptr_r;
  logic [NREQ-1:0] gnt_r;
  logic [3:0]      gap_r;
  logic [11:0]     wc_r;
  logic [15:0]     txd_r;
  logic            tx_vld_r, tx_sof_r, tx_eof_r;
  logic [15:0]     evt_r;
  logic [11:0]     wrd_r;
  logic [2:0]      err_r;

  logic [NREQ-1:0] sel_s;
  logic            sel_vld_s;
  logic [PW-1:0]   sel_idx_s, ptr_nxt_s;
  logic [15:0]     g_dout_s;
  logic            g_dv_s, g_last_s, g_req_s, stray_s, tmo_hit_s, abort_s;
  logic [11:0]     wc_nxt_s;
  logic [2:0]      err_set_s;

  rr_prio_enc #(.NREQ(NREQ), .PW(PW)) u_enc (
    .REQ (REQ),
    .PTR (ptr_r),
    .SEL (sel_s),
    .VLD (sel_vld_s)
  );

`ifdef CHANLINK_ARB_TMO_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_r;

  // Counts GRANT cycles spent waiting for the first word.
  always_ff @(posedge RCLK) begin
    if (RST) begin
      tmo_r <= {TW{1'b0}};
    end else if (state_r != ST_GRANT) begin
      tmo_r <= {TW{1'b0}};
    end else begin
      tmo_r <= tmo_r + TW'(1);
    end
  end

  assign tmo_hit_s = (state_r == ST_GRANT) && (tmo_r == TW'(TMO_CYC - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Granted-source view: gnt_r is one-hot or zero, so AND-OR acts as the mux.
  always_comb begin
    g_dout_s  = 16'h0000;
    sel_idx_s = {PW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      g_dout_s  = g_dout_s | (DOUT[16*i +: 16] & {16{gnt_r[i]}});
      sel_idx_s = sel_idx_s | (PW'(i) & {PW{sel_s[i]}});
    end
    ptr_nxt_s = (sel_idx_s == PW'(NREQ - 1)) ? {PW{1'b0}} : sel_idx_s + PW'(1);
    g_dv_s    = |(DVALID & gnt_r);
    g_last_s  = |(DVALID & LAST_WRD & gnt_r);
    g_req_s   = |(REQ & gnt_r);
    stray_s   = |(DVALID & ~gnt_r);
    wc_nxt_s  = (state_r == ST_GRANT) ? 12'd1 : sat_inc12(wc_r);
    err_set_s            = 3'b000;
    err_set_s[ERR_STRAY] = stray_s;
    err_set_s[ERR_TRUNC] = (state_r == ST_GRANT) && !g_dv_s && !g_req_s;
    err_set_s[ERR_TMO]   = (state_r == ST_GRANT) && !g_dv_s && g_req_s && tmo_hit_s;
    abort_s              = err_set_s[ERR_TRUNC] | err_set_s[ERR_TMO];
  end

  // Arbitration FSM, TX output register, event counters and sticky errors.
  always_ff @(posedge RCLK) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      ptr_r    <= {PW{1'b0}};
      gnt_r    <= {NREQ{1'b0}};
      gap_r    <= 4'd0;
      wc_r     <= 12'd0;
      txd_r    <= IDLE_WRD;
      tx_vld_r <= 1'b0;
      tx_sof_r <= 1'b0;
      tx_eof_r <= 1'b0;
      evt_r    <= 16'd0;
      wrd_r    <= 12'd0;
      err_r    <= 3'b000;
    end else begin
      txd_r    <= IDLE_WRD;
      tx_vld_r <= 1'b0;
      tx_sof_r <= 1'b0;
      tx_eof_r <= 1'b0;
      err_r    <= (CLR_ERR ? 3'b000 : err_r) | err_set_s;
      case (state_r)
        ST_IDLE: begin
          if (sel_vld_s) begin
            gnt_r   <= sel_s;
            ptr_r   <= ptr_nxt_s;
            state_r <= ST_GRANT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT, ST_XFER: begin
          if (g_dv_s) begin
            txd_r    <= g_dout_s;
            tx_vld_r <= 1'b1;
            tx_sof_r <= (state_r == ST_GRANT);
            wc_r     <= wc_nxt_s;
            if (g_last_s) begin
              tx_eof_r <= 1'b1;
              evt_r    <= evt_r + 16'd1;
              wrd_r    <= wc_nxt_s;
              gnt_r    <= {NREQ{1'b0}};
              gap_r    <= 4'd0;
              state_r  <= ST_GAP;
            end else begin
              state_r  <= ST_XFER;
            end
          end else if (abort_s) begin
            gnt_r   <= {NREQ{1'b0}};
            gap_r   <= 4'd0;
            state_r <= ST_GAP;
          end else begin
            state_r <= state_r;
          end
        end
        ST_GAP: begin
          // One extra GAP cycle: the first one still shows the EOF word on TXD.
          if (gap_r == 4'(IDLE_GAP)) begin
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_r + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt_r   <= {NREQ{1'b0}};
        end
      endcase
    end
  end

  assign GNT      = gnt_r;
  assign TXD      = txd_r;
  assign TX_VLD   = tx_vld_r;
  assign TX_SOF   = tx_sof_r;
  assign TX_EOF   = tx_eof_r;
  assign EVT_CNT  = evt_r;
  assign WRD_CNT  = wrd_r;
  assign ERR_STAT = err_r;

endmodule

// File: tb/tb_chanlink_evt_arb.sv
// Randomized self-checking bench for chanlink_evt_arb; the reference model
// predicts grants, forwarded words, counters and sticky errors from the rules.
module tb_chanlink_evt_arb;

  localparam int          NREQ     = 4;
  localparam int          IDLE_GAP = 2;
  localparam int          TMO_CYC  = 15;
  localparam logic [15:0] IDLE_W   = 16'h50BC;

  logic              RCLK, RST, CLR_ERR;
  logic [NREQ-1:0]   REQ, DVALID, LAST_WRD, GNT;
  logic [16*NREQ-1:0] DOUT;
  logic [15:0]       TXD, EVT_CNT;
  logic              TX_VLD, TX_SOF, TX_EOF;
  logic [11:0]       WRD_CNT;
  logic [2:0]        ERR_STAT;

  chanlink_evt_arb #(.NREQ(NREQ), .IDLE_GAP(IDLE_GAP), .TMO_CYC(TMO_CYC), .IDLE_WRD(IDLE_W)) dut (
    .RCLK(RCLK), .RST(RST), .REQ(REQ), .DVALID(DVALID), .DOUT(DOUT), .LAST_WRD(LAST_WRD),
    .CLR_ERR(CLR_ERR), .GNT(GNT), .TXD(TXD), .TX_VLD(TX_VLD), .TX_SOF(TX_SOF), .TX_EOF(TX_EOF),
    .EVT_CNT(EVT_CNT), .WRD_CNT(WRD_CNT), .ERR_STAT(ERR_STAT)
  );

  initial RCLK = 1'b0;
  always #5 RCLK = ~RCLK;

  int          n_tot = 0;
  int          n_bad = 0;
  int          ptr_m = 0;
  int          since_eof = 0;
  logic [15:0] evt_m = 16'd0;
  logic [2:0]  err_m = 3'b000;
  int          g, cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge RCLK);
    #1;
    since_eof++;
  endtask

  // Predict the round-robin winner, then wait (bounded) for the grant.
  task automatic wait_gnt(input int exp_wait, output int gw);
    int  waitc;
    bit  found;
    found = 1'b0;
    gw    = 0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr_m + k) % NREQ;
      if (!found && REQ[j]) begin
        gw    = j;
        found = 1'b1;
      end
    end
    ptr_m = (gw + 1) % NREQ;
    waitc = 0;
    while (GNT == 4'b0000 && waitc < 64) begin
      step();
      waitc++;
    end
    if (exp_wait >= 0) chk("gnt_delay", 32'(since_eof), 32'(exp_wait));
    chk("gnt", 32'(GNT), 32'(1) << gw);
  endtask

  // One event from the predicted source; gapmode 0=none 1=random 2=alternate.
  task automatic do_event(input int nw, input int gapmode, input bit seq,
                          input int stray_at, input int exp_wait);
    int          gs, w, cyc;
    bit          drv;
    logic [15:0] wd;
    wait_gnt(exp_wait, gs);
    w   = 0;
    cyc = 0;
    while (w < nw && cyc < 4 * nw + 64) begin
      drv = (gapmode == 0) ? 1'b1 : (gapmode == 1) ? ($urandom_range(2) != 0) : (cyc % 2 == 0);
      wd  = seq ? 16'(w) : 16'($urandom);
      DOUT     = {$urandom, $urandom};
      DVALID   = 4'b0000;
      LAST_WRD = 4'b0000;
      if (drv) begin
        DVALID[gs]         = 1'b1;
        DOUT[16*gs +: 16]  = wd;
        LAST_WRD[gs]       = (w == nw - 1);
      end else begin
        LAST_WRD[gs]       = 1'($urandom_range(1));
      end
      if (cyc == stray_at) begin
        DVALID[(gs + 1) % NREQ] = 1'b1;
        err_m[2] = 1'b1;
      end
      step();
      chk("tx_vld", 32'(TX_VLD), 32'(drv));
      chk("txd", 32'(TXD), drv ? 32'(wd) : 32'(IDLE_W));
      chk("tx_sof", 32'(TX_SOF), 32'(drv && w == 0));
      chk("tx_eof", 32'(TX_EOF), 32'(drv && w == nw - 1));
      chk("gnt_hold", 32'(GNT), (drv && w == nw - 1) ? 32'(0) : (32'(1) << gs));
      if (drv) w++;
      cyc++;
    end
    since_eof = 0;
    DVALID    = 4'b0000;
    LAST_WRD  = 4'b0000;
    evt_m     = evt_m + 16'd1;
    chk("evt_cnt", 32'(EVT_CNT), 32'(evt_m));
    chk("wrd_cnt", 32'(WRD_CNT), (nw > 4095) ? 32'(4095) : 32'(nw));
    chk("err_stat", 32'(ERR_STAT), 32'(err_m));
  endtask

  initial begin
    RST = 1'b1; CLR_ERR = 1'b0; REQ = 4'b0000; DVALID = 4'b0000;
    LAST_WRD = 4'b0000; DOUT = 64'd0;
    repeat (3) step();
    chk("rst_gnt", 32'(GNT), 32'(0));
    chk("rst_txd", 32'(TXD), 32'(IDLE_W));
    chk("rst_vld", 32'(TX_VLD), 32'(0));
    chk("rst_sof", 32'(TX_SOF), 32'(0));
    chk("rst_eof", 32'(TX_EOF), 32'(0));
    chk("rst_evt", 32'(EVT_CNT), 32'(0));
    chk("rst_wrd", 32'(WRD_CNT), 32'(0));
    chk("rst_err", 32'(ERR_STAT), 32'(0));
    RST = 1'b0;
    step();

    // Single source, sequential 100-word event.
    REQ = 4'b0001; since_eof = 0;
    do_event(100, 0, 1'b1, -1, 1);

    // Fairness with all sources requesting.
    REQ = 4'b1111;
    for (int e = 0; e < 5; e++) do_event(4, 0, 1'b0, -1, IDLE_GAP + 2);

    // Stray DVALID from another source and alternating gaps.
    REQ = 4'b0010;
    do_event(3, 2, 1'b0, 1, IDLE_GAP + 2);
    CLR_ERR = 1'b1;
    step();
    err_m = 3'b000;
    chk("clr_err", 32'(ERR_STAT), 32'(err_m));
    CLR_ERR = 1'b0;

    // REQ withdrawn before any data: truncation abort.
    REQ = 4'b0001;
    wait_gnt(-1, g);
    REQ = 4'b0000;
    step();
    err_m[1] = 1'b1;
    chk("trunc_gnt", 32'(GNT), 32'(0));
    chk("trunc_err", 32'(ERR_STAT), 32'(err_m));
    chk("trunc_evt", 32'(EVT_CNT), 32'(evt_m));
    CLR_ERR = 1'b1; DVALID = 4'b0100;
    step();
    err_m = 3'b100;
    chk("clr_vs_new", 32'(ERR_STAT), 32'(err_m));
    DVALID = 4'b0000;
    step();
    err_m = 3'b000;
    chk("clr_err2", 32'(ERR_STAT), 32'(err_m));
    CLR_ERR = 1'b0;
    repeat (6) step();

`ifdef CHANLINK_ARB_TMO_EN
    REQ = 4'b1000;
    wait_gnt(-1, g);
    cnt = 0;
    while (GNT != 4'b0000 && cnt < 200) begin
      step();
      cnt++;
    end
    err_m[0] = 1'b1;
    chk("tmo_cyc", 32'(cnt), 32'(TMO_CYC));
    chk("tmo_err", 32'(ERR_STAT), 32'(err_m));
    chk("tmo_evt", 32'(EVT_CNT), 32'(evt_m));
    CLR_ERR = 1'b1;
    step();
    err_m = 3'b000;
    chk("tmo_clr", 32'(ERR_STAT), 32'(err_m));
    CLR_ERR = 1'b0;
    REQ = 4'b0000;
    repeat (6) step();
`endif

    // Random request patterns, lengths and DVALID gaps.
    REQ = 4'b0000;
    repeat (8) step();
    since_eof = 0;
    for (int e = 0; e < 40; e++) begin
      REQ = 4'($urandom_range(15, 1));
      do_event(int'($urandom_range(12, 1)), int'($urandom_range(1)), 1'b0, -1,
               (e == 0) ? 1 : IDLE_GAP + 2);
    end

    // Word-count saturation.
    REQ = 4'b0001;
    do_event(5000, 0, 1'b0, -1, IDLE_GAP + 2);

    // Reset in the middle of an event.
    REQ = 4'b0100;
    wait_gnt(-1, g);
    for (int i = 0; i < 10; i++) begin
      DVALID = 4'b0000;
      DVALID[g] = 1'b1;
      DOUT[16*g +: 16] = 16'(i + 16'h0100);
      step();
      chk("pre_rst_txd", 32'(TXD), 32'(i + 16'h0100));
    end
    RST = 1'b1; DVALID = 4'b0000;
    step();
    RST = 1'b0;
    chk("mid_rst_gnt", 32'(GNT), 32'(0));
    chk("mid_rst_txd", 32'(TXD), 32'(IDLE_W));
    chk("mid_rst_vld", 32'(TX_VLD), 32'(0));
    chk("mid_rst_eof", 32'(TX_EOF), 32'(0));
    chk("mid_rst_evt", 32'(EVT_CNT), 32'(0));
    chk("mid_rst_wrd", 32'(WRD_CNT), 32'(0));
    ptr_m = 0; evt_m = 16'd0; err_m = 3'b000;
    REQ = 4'b0010; since_eof = 0;
    do_event(6, 1, 1'b0, -1, 1);

    REQ = 4'b0000;
    repeat (4) step();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
